uart_rx_intc: RTL and testbench

- 8N1 UART receiver peripheral for the KCPSM3 system.
- Deserialises the rx line into a small FIFO and presents data and status on the processor read port.
- Requests service over the interrupt/interrupt_ack handshake and acts as the responder to the processor's interrupt acknowledge.
- Sits between the Nexys2 RS-232 pin and the embedded_kcpsm3 in_port/interrupt inputs.

---
 rtl/uart_rx_intc.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_intc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_intc.sv
// uart_rx_intc: 8N1 UART receiver with FIFO, status port and irq handshake.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx_intc #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_AW      = 2,
  parameter logic [7:0] RX_PORT_ID   = 8'h00,
  parameter logic [7:0] STAT_PORT_ID = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [11:0] HALF_CNT = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] FULL_CNT = 12'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IRQ_IDLE, IRQ_REQ, IRQ_WAIT
  } irq_state_t;

  rx_state_t  rx_state;
  irq_state_t irq_state;

  logic             rx_s1, rx_s2, rx_prev;
  logic [11:0]      cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic             overrun, framing_err, parity_err;
  logic             empty, full, stop_evt, par_ok;
  logic             push, pop, rd_data, rd_stat;
  logic             ovf_set, ferr_set, perr_set;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign empty    = (count == '0);
  assign full     = (count == FULL_LVL);
  assign stop_evt = (rx_state == STOP) && (cnt == '0);
  assign rd_data  = read_strobe && (port_id == RX_PORT_ID);
  assign rd_stat  = read_strobe && (port_id == STAT_PORT_ID);
  assign pop      = rd_data && !empty;

  // a pop on a full FIFO frees the slot for this cycle's push
  assign push     = stop_evt && rx_s2 && par_ok && (!full || pop);
  assign ovf_set  = stop_evt && rx_s2 && par_ok && full && !pop;
  assign ferr_set = stop_evt && !rx_s2;
  assign perr_set = stop_evt && rx_s2 && !par_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      unique case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            cnt      <= HALF_CNT;
            rx_state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s2) begin
              rx_state <= DATA;
              cnt      <= FULL_CNT;
              idx      <= '0;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[idx] <= rx_s2;
            cnt        <= FULL_CNT;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - 12'd1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (cnt == '0) begin
            par_bit  <= rx_s2;
            cnt      <= FULL_CNT;
            rx_state <= STOP;
          end else begin
            cnt <= cnt - 12'd1;
          end
`else
          rx_state <= IDLE;
`endif
        end
        STOP: begin
          if (cnt == '0) rx_state <= IDLE;
          else           cnt      <= cnt - 12'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_port     <= 8'h00;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      unique case (1'b1)
        (port_id == RX_PORT_ID):
          in_port <= empty ? 8'h00 : mem[rd_ptr];
        (port_id == STAT_PORT_ID):
          in_port <= {3'b000, parity_err, framing_err,
                      overrun, full, !empty};
        default:
          in_port <= 8'h00;
      endcase
      // a flag raised on the clearing read survives it
      overrun     <= ovf_set  | (overrun     & !rd_stat);
      framing_err <= ferr_set | (framing_err & !rd_stat);
      parity_err  <= perr_set | (parity_err  & !rd_stat);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_state <= IRQ_IDLE;
      interrupt <= 1'b0;
    end else begin
      unique case (irq_state)
        IRQ_IDLE: begin
          if (!empty) begin
            irq_state <= IRQ_REQ;
            interrupt <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (interrupt_ack) begin
            irq_state <= IRQ_WAIT;
            interrupt <= 1'b0;
          end
        end
        IRQ_WAIT: begin
          if (rd_data) irq_state <= IRQ_IDLE;
        end
        default: begin
          irq_state <= IRQ_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_intc.sv
// tb_uart_rx_intc: scoreboard bench for the UART receiver peripheral.
// Expected bytes are queued as frames are sent and popped on data reads.
`timescale 1ns/1ps
module tb_uart_rx_intc;

  localparam int         CPB = 16;
  localparam logic [7:0] RXP = 8'h00;
  localparam logic [7:0] STP = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d;
  int         rise;

  uart_rx_intc #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(2),
    .RX_PORT_ID(RXP),
    .STAT_PORT_ID(STP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .port_id(port_id),
    .read_strobe(read_strobe),
    .in_port(in_port),
    .interrupt(interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // rise = first cycle in the stop bit where interrupt is seen high
  task automatic send_frame(input logic [7:0] v, input logic stop,
                            input logic accept, output int r);
    r = 0;
    if (accept) exp_q.push_back(v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^v);
`endif
    rx = stop;
    for (int k = 1; k <= CPB; k++) begin
      @(negedge clk);
      if (interrupt && r == 0) r = k;
    end
    rx = 1'b1;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] v);
    port_id = id;
    @(negedge clk);
    v = in_port;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    rd(RXP, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    chk(tag, v, e);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
  endtask

  task automatic irq_clear();
    logic [7:0] v;
    if (interrupt) ack();
    rd(RXP, v);
    idle(3);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_irq", interrupt, 1'b0);
    reset = 1'b1;
    idle(3 * CPB);
    chk("idle_irq", interrupt, 1'b0);
    rd(STP, d);
    chk("idle_stat", d, 8'h00);
    rd_data_chk("idle_data");

    send_frame(8'hA5, 1'b1, 1'b1, rise);
    chk("a5_irq_rise", (rise >= 9 && rise <= 13), 1'b1);
    chk("a5_irq_hi", interrupt, 1'b1);
    ack();
    chk("a5_ack_low", interrupt, 1'b0);
    rd_data_chk("a5_data");
    rd(STP, d);
    chk("a5_stat", d, 8'h00);
    idle(3);
    chk("a5_irq_idle", interrupt, 1'b0);

    send_frame(8'h11, 1'b1, 1'b1, rise);
    send_frame(8'h22, 1'b1, 1'b1, rise);
    send_frame(8'h33, 1'b1, 1'b1, rise);
    send_frame(8'h44, 1'b1, 1'b1, rise);
    send_frame(8'h55, 1'b1, 1'b0, rise);
    idle(2);
    rd(STP, d);
    chk("ovr_stat1", d, 8'h07);
    rd(STP, d);
    chk("ovr_stat2", d, 8'h03);
    for (int i = 0; i < 5; i++) rd_data_chk($sformatf("ovr_data%0d", i));
    irq_clear();
    chk("ovr_irq_clr", interrupt, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0, rise);
    idle(4);
    chk("ferr_irq", interrupt, 1'b0);
    rd(STP, d);
    chk("ferr_stat", d, 8'h08);
    rd(STP, d);
    chk("ferr_stat_clr", d, 8'h00);
    rd_data_chk("ferr_data");

    rx = 1'b0;
    idle(CPB / 4);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_irq", interrupt, 1'b0);
    rd(STP, d);
    chk("glitch_stat", d, 8'h00);

    send_frame(8'h5A, 1'b1, 1'b1, rise);
    send_frame(8'hC3, 1'b1, 1'b1, rise);
    idle(4);
    chk("two_irq_hi", interrupt, 1'b1);
    ack();
    chk("two_ack_low", interrupt, 1'b0);
    port_id = RXP;
    @(negedge clk);
    d = in_port;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    chk("two_gap", interrupt, 1'b0);
    @(negedge clk);
    chk("two_rearm", interrupt, 1'b1);
    chk("two_data", d, exp_q.pop_front());
    chk("two_head", in_port, exp_q[0]);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #5 reset = 1'b0;
    #1;
    chk("mid_rst_in_port", in_port, 8'h00);
    chk("mid_rst_irq", interrupt, 1'b0);
    exp_q.delete();
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle(3 * CPB);
    chk("post_rst_irq", interrupt, 1'b0);
    rd(STP, d);
    chk("post_rst_stat", d, 8'h00);
    rd_data_chk("post_rst_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
